// File: rtl/conv_5_feeder.sv
// Streams a 5x5 kernel and then an image from a single-port pixel RAM into the
// convolution engine as 5-pixel columns, tagging each captured window.
module conv_5_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 5,
    parameter int IMG_WIDTH   = 32,
    parameter int IMG_HEIGHT  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int KERNEL_BASE = 0,
    parameter int IMAGE_BASE  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] conv_data0,
    output logic [DATA_WIDTH-1:0] conv_data1,
    output logic [DATA_WIDTH-1:0] conv_data2,
    output logic [DATA_WIDTH-1:0] conv_data3,
    output logic [DATA_WIDTH-1:0] conv_data4,
    output logic                  conv_valid_in,
    output logic                  conv_kernel_load,
    output logic                  conv_valid_out,
    output logic [$clog2(IMG_HEIGHT-KERNEL_SIZE+1)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH-KERNEL_SIZE+1)-1:0]  out_col
);

    localparam int OR_W = $clog2(IMG_HEIGHT - KERNEL_SIZE + 1);
    localparam int OC_W = $clog2(IMG_WIDTH - KERNEL_SIZE + 1);
    localparam int C_W  = $clog2(IMG_WIDTH);
    localparam logic [2:0] LAST_ROW = 3'(KERNEL_SIZE - 1);
    localparam logic [2:0] PUSH_PH  = 3'(KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] KB     = ADDR_WIDTH'(KERNEL_BASE);
    localparam logic [ADDR_WIDTH-1:0] IB     = ADDR_WIDTH'(IMAGE_BASE);
    localparam logic [ADDR_WIDTH-1:0] K_STEP = ADDR_WIDTH'(KERNEL_SIZE);
    localparam logic [ADDR_WIDTH-1:0] I_STEP = ADDR_WIDTH'(IMG_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_KERNEL, S_IMAGE, S_FLUSH, S_DONE
    } state_t;

    state_t                 state;
    logic [2:0]             ph;
    logic [2:0]             kc;
    logic [C_W-1:0]         ci;
    logic [OR_W-1:0]        band;
    logic [ADDR_WIDTH-1:0]  col_base;
    logic [DATA_WIDTH-1:0]  col    [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]  merged [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]  push_d [KERNEL_SIZE];
    logic                   pend;
    logic [2:0]             pend_row;
    logic                   win_ok, cap_pend;
    logic [OR_W-1:0]        win_row, cap_row;
    logic [OC_W-1:0]        win_col, cap_col;
    logic                   last_k, last_c, last_b, win_full;

    assign last_k   = (kc == LAST_ROW);
    assign last_c   = (ci == C_W'(IMG_WIDTH - 1));
    assign last_b   = (band == OR_W'(IMG_HEIGHT - KERNEL_SIZE));
    assign win_full = (ci >= C_W'(KERNEL_SIZE - 1));

    assign conv_data0 = push_d[0];
    assign conv_data1 = push_d[1];
    assign conv_data2 = push_d[2];
    assign conv_data3 = push_d[3];
    assign conv_data4 = push_d[4];

    // Bottom row returns in the push cycle itself, so bypass it into the push
    always_comb begin
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            merged[i] = (pend && pend_row == 3'(i)) ? rd_data : col[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            ph               <= '0;
            kc               <= '0;
            ci               <= '0;
            band             <= '0;
            col_base         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            rd_en            <= 1'b0;
            rd_addr          <= '0;
            pend             <= 1'b0;
            pend_row         <= '0;
            conv_valid_in    <= 1'b0;
            conv_kernel_load <= 1'b0;
            conv_valid_out   <= 1'b0;
            out_row          <= '0;
            out_col          <= '0;
            win_ok           <= 1'b0;
            win_row          <= '0;
            win_col          <= '0;
            cap_pend         <= 1'b0;
            cap_row          <= '0;
            cap_col          <= '0;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                col[i]    <= '0;
                push_d[i] <= '0;
            end
        end else begin
            done             <= 1'b0;
            rd_en            <= 1'b0;
            conv_valid_in    <= 1'b0;
            conv_kernel_load <= 1'b0;
            cap_pend         <= 1'b0;
            pend             <= rd_en;
            pend_row         <= ph;
            for (int i = 0; i < KERNEL_SIZE; i++) begin
                push_d[i] <= '0;
                if (pend && pend_row == 3'(i)) col[i] <= rd_data;
            end
            conv_valid_out <= cap_pend;
            if (cap_pend) begin
                out_row <= cap_row;
                out_col <= cap_col;
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_KERNEL;
                        busy     <= 1'b1;
                        ph       <= '0;
                        kc       <= '0;
                        ci       <= '0;
                        band     <= '0;
                        col_base <= KB;
                        rd_en    <= 1'b1;
                        rd_addr  <= KB;
                    end
                end
                S_KERNEL, S_IMAGE, S_FLUSH: begin
                    ph <= (ph == PUSH_PH) ? 3'd0 : ph + 3'd1;
                    if (state != S_FLUSH && ph < LAST_ROW) begin
                        rd_en   <= 1'b1;
                        rd_addr <= rd_addr + ((state == S_KERNEL) ? K_STEP : I_STEP);
                    end
                    if (ph == PUSH_PH) begin
                        conv_valid_in    <= 1'b1;
                        conv_kernel_load <= (state == S_KERNEL);
                        if (state != S_FLUSH) begin
                            for (int i = 0; i < KERNEL_SIZE; i++) push_d[i] <= merged[i];
                        end
                        // Engine captures the window that ended at the previous column
                        cap_pend <= win_ok && (state != S_KERNEL);
                        cap_row  <= win_row;
                        cap_col  <= win_col;
                        win_ok   <= (state == S_IMAGE) && win_full;
                        win_row  <= band;
                        win_col  <= OC_W'(ci - C_W'(KERNEL_SIZE - 1));
                        if (state == S_KERNEL) begin
                            rd_en <= 1'b1;
                            if (last_k) begin
                                state    <= S_IMAGE;
                                col_base <= IB;
                                rd_addr  <= IB;
                            end else begin
                                kc       <= kc + 3'd1;
                                col_base <= col_base + ADDR_WIDTH'(1);
                                rd_addr  <= col_base + ADDR_WIDTH'(1);
                            end
                        end else if (state == S_IMAGE) begin
                            col_base <= col_base + ADDR_WIDTH'(1);
                            rd_addr  <= col_base + ADDR_WIDTH'(1);
                            if (last_c) begin
                                ci <= '0;
                                if (last_b) begin
                                    state <= S_FLUSH;
                                end else begin
                                    band  <= band + OR_W'(1);
                                    rd_en <= 1'b1;
                                end
                            end else begin
                                ci    <= ci + C_W'(1);
                                rd_en <= 1'b1;
                            end
                        end else begin
                            state <= S_DONE;
                            ph    <= '0;
                        end
                    end
                end
                S_DONE: begin
                    ph <= ph + 3'd1;
                    if (ph == 3'd1) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                    if (ph == 3'd2) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_5_feeder.sv
// Directed bench for conv_5_feeder: a RAM model, a cycle table checked against
// frame timing, and sequences for reset, abandoned frames and ignored starts.
module tb_conv_5_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, rd_en;
    logic [11:0] rd_addr;
    logic [15:0] rd_data = '0;
    logic [15:0] d0, d1, d2, d3, d4;
    logic        vin, kl, vout;
    logic [4:0]  orow, ocol;

    conv_5_feeder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .conv_data0(d0), .conv_data1(d1), .conv_data2(d2),
        .conv_data3(d3), .conv_data4(d4),
        .conv_valid_in(vin), .conv_kernel_load(kl),
        .conv_valid_out(vout), .out_row(orow), .out_col(ocol)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [4096];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'hdead;

    int cyc = 0;
    int c0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    bit mon_en = 0;
    int kl_cnt, nk_cnt, vo_cnt, tag_err, first_vo, done_cnt, done_cyc, er, ec;

    always @(negedge clk) begin
        if (mon_en) begin
            if (vin) begin
                if (kl) kl_cnt++;
                else nk_cnt++;
            end
            if (vout) begin
                if (vo_cnt == 0) first_vo = cyc - c0;
                if (int'(orow) != er || int'(ocol) != ec) tag_err++;
                vo_cnt++;
                if (ec == 27) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - c0;
            end
        end
    end

    typedef struct {
        int cyc;
        bit busy, done, rd_en;
        int addr;
        bit vin, kl;
        int d [5];
        bit vout;
        int orow, ocol;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(int c, bit b, bit dn, bit re, int a, bit vi,
                                bit k, int x0, int x1, int x2, int x3, int x4,
                                bit vo, int r, int cc);
        vec_t v;
        v.cyc = c; v.busy = b; v.done = dn; v.rd_en = re; v.addr = a;
        v.vin = vi; v.kl = k;
        v.d[0] = x0; v.d[1] = x1; v.d[2] = x2; v.d[3] = x3; v.d[4] = x4;
        v.vout = vo; v.orow = r; v.ocol = cc;
        return v;
    endfunction

    task automatic wait_rel(input int n);
        while (cyc - c0 < n) @(negedge clk);
    endtask

    task automatic clear_mon();
        mon_en = 0;
        kl_cnt = 0; nk_cnt = 0; vo_cnt = 0; tag_err = 0;
        first_vo = -1; done_cnt = 0; done_cyc = -1; er = 0; ec = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        clear_mon();
        start = 1'b1;
        c0 = cyc;
        mon_en = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_table(input int limit);
        int got [5];
        foreach (tbl[n]) begin
            if (tbl[n].cyc <= limit) begin
                wait_rel(tbl[n].cyc);
                got = '{int'(d0), int'(d1), int'(d2), int'(d3), int'(d4)};
                chk($sformatf("c%0d_busy", tbl[n].cyc), int'(busy), int'(tbl[n].busy));
                chk($sformatf("c%0d_done", tbl[n].cyc), int'(done), int'(tbl[n].done));
                chk($sformatf("c%0d_rd_en", tbl[n].cyc), int'(rd_en), int'(tbl[n].rd_en));
                if (tbl[n].rd_en)
                    chk($sformatf("c%0d_rd_addr", tbl[n].cyc), int'(rd_addr), tbl[n].addr);
                chk($sformatf("c%0d_valid_in", tbl[n].cyc), int'(vin), int'(tbl[n].vin));
                chk($sformatf("c%0d_kernel_load", tbl[n].cyc), int'(kl), int'(tbl[n].kl));
                for (int i = 0; i < 5; i++)
                    chk($sformatf("c%0d_data%0d", tbl[n].cyc, i), got[i], tbl[n].d[i]);
                chk($sformatf("c%0d_valid_out", tbl[n].cyc), int'(vout), int'(tbl[n].vout));
                if (tbl[n].vout) begin
                    chk($sformatf("c%0d_out_row", tbl[n].cyc), int'(orow), tbl[n].orow);
                    chk($sformatf("c%0d_out_col", tbl[n].cyc), int'(ocol), tbl[n].ocol);
                end
            end
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_rd_en"}, int'(rd_en), 0);
        chk({nm, "_rd_addr"}, int'(rd_addr), 0);
        chk({nm, "_push"}, int'(vin | kl | vout), 0);
        chk({nm, "_data"}, int'(|{d0, d1, d2, d3, d4}), 0);
        chk({nm, "_tag"}, int'({orow, ocol}), 0);
    endtask

    initial begin
        tbl.push_back(mk(1,    1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2,    1, 0, 1, 5,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5,    1, 0, 1, 20,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6,    1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(7,    1, 0, 1, 1,   1, 1, 0, 10, 20, 30, 40, 0, 0, 0));
        tbl.push_back(mk(8,    1, 0, 1, 6,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(19,   1, 0, 1, 3,   1, 1, 2, 12, 22, 32, 42, 0, 0, 0));
        tbl.push_back(mk(31,   1, 0, 1, 32,  1, 1, 4, 14, 24, 34, 44, 0, 0, 0));
        tbl.push_back(mk(35,   1, 0, 1, 160, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(37,   1, 0, 1, 33,  1, 0, 0, 32, 64, 96, 128, 0, 0, 0));
        tbl.push_back(mk(38,   1, 0, 1, 65,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(67,   1, 0, 1, 38,  1, 0, 5, 37, 69, 101, 133, 0, 0, 0));
        tbl.push_back(mk(68,   1, 0, 1, 70,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(74,   1, 0, 1, 71,  0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(223,  1, 0, 1, 64,  1, 0, 31, 63, 95, 127, 159, 0, 0, 0));
        tbl.push_back(mk(224,  1, 0, 1, 96,  0, 0, 0, 0, 0, 0, 0, 1, 0, 26));
        tbl.push_back(mk(229,  1, 0, 1, 65,  1, 0, 32, 64, 96, 128, 160, 0, 0, 0));
        tbl.push_back(mk(230,  1, 0, 1, 97,  0, 0, 0, 0, 0, 0, 0, 1, 0, 27));
        tbl.push_back(mk(236,  1, 0, 1, 98,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5407, 1, 0, 0, 0,   1, 0, 895, 927, 959, 991, 1023, 0, 0, 0));
        tbl.push_back(mk(5408, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 27, 26));
        tbl.push_back(mk(5413, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5414, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 27, 27));
        tbl.push_back(mk(5415, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(5416, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int a = 0; a < 4096; a++) mem[a] = 16'h5a5a;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mem[r * 5 + c] = 16'(10 * r + c);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) mem[32 + r * 32 + c] = 16'(r * 32 + c);
        clear_mon();

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("post_reset");

        // Frame abandoned by a reset in the middle of the image phase
        do_start();
        run_table(1999);
        wait_rel(2000);
        chk("pre_abort_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk_idle("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk_idle("abort_idle");
        chk("abort_done_count", done_cnt, 0);

        // Full frame with stray starts while busy and during the done pulse
        do_start();
        fork
            run_table(1000000);
            begin
                wait_rel(100);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                wait_rel(5415);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        wait_rel(5440);
        chk("kernel_pushes", kl_cnt, 5);
        chk("nonkernel_pushes", nk_cnt, 897);
        chk("valid_out_count", vo_cnt, 784);
        chk("tag_order_errors", tag_err, 0);
        chk("first_valid_out_cycle", first_vo, 68);
        chk("done_cycle", done_cyc, 5415);
        chk("done_count", done_cnt, 1);
        chk("final_busy", int'(busy), 0);
        chk("final_rd_en", int'(rd_en), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_5_feeder.md
# conv_5_feeder

Sequencer/streamer that drives the 5x5 convolution engine from a single-port pixel memory. On `start` it fetches the 5x5 kernel and then the whole image, assembles 5-pixel vertical columns, and pushes them to the engine with `kernel_load` / `valid_in` / `valid_out` timing matched to its column-shift window and result registers. It sits between the layer-0 image/kernel RAM and the convolution engine, and tags each emitted result with its output coordinates.

## Interface
- `DATA_WIDTH`, 16: pixel/weight width.
- `KERNEL_SIZE`, 5: K; window is KxK, stride 1, no padding.
- `IMG_WIDTH`, 32: image columns W.
- `IMG_HEIGHT`, 32: image rows H.
- `ADDR_WIDTH`, 12: memory address width.
- `KERNEL_BASE`, 0: address of kernel (kr,kc) = KERNEL_BASE + kr*K + kc.
- `IMAGE_BASE`, 32: address of pixel (r,c) = IMAGE_BASE + r*W + c.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at end of frame.
- `rd_en`  out  1  memory read strobe.
- `rd_addr`  out  ADDR_WIDTH  read address.
- `rd_data`  in  DATA_WIDTH  read data, valid the cycle after `rd_en`.
- `conv_data0`..`conv_data4`  out  DATA_WIDTH each  column pixels, `conv_data_i` = row (top+i).
- `conv_valid_in`  out  1  column push strobe.
- `conv_kernel_load`  out  1  qualifies push as kernel column.
- `conv_valid_out`  out  1  result-capture strobe to engine.
- `out_row`, `out_col`  out  $clog2(H-K+1), $clog2(W-K+1)  coordinates of window captured by `conv_valid_out`.

## Operation
- FSM: IDLE -> KERNEL (5 columns) -> IMAGE (bands b=0..H-K, columns c=0..W-1, c fastest) -> FLUSH -> DONE -> IDLE.
- Column period is exactly 6 cycles: cycles 0-4 issue `rd_en` for rows top..top+4 of current column (top=0 for kernel, b for image); data captured into column register as it returns; cycle 5 no read.
- Push: `conv_data*`, `conv_valid_in` (and `conv_kernel_load` for KERNEL columns) are registered and high for exactly one cycle, at cycle 0 of the following period; all push outputs return to 0 otherwise (data held is don't-care but driven 0).
- Kernel columns pushed kc=0..4 with `conv_data_i` = kernel(i,kc), same orientation as image.
- Engine captures the pre-shift window on each non-kernel push; therefore window (b, c-K+1) ending at image column c (c>=K-1) is captured by the next push: column c+1 of band b, column 0 of band b+1, or the FLUSH push.
- `conv_valid_out` pulses the cycle after each capturing push, with `out_row`/`out_col` valid that cycle. Pushes of columns 0..K-1 within a band produce no `conv_valid_out` (except column 0 capturing previous band's last window).
- FLUSH: one push of all-zero data, `conv_kernel_load`=0, at the regular 6-cycle cadence, no reads.
- Window count per frame: (W-K+1)*(H-K+1); 784 for defaults.
- `start` while busy ignored; `rd_data` ignored when no read outstanding.

## Timing
- Reset (async, any state): FSM IDLE; `busy`, `done`, `rd_en`, `rd_addr`, all `conv_*`, `out_row`, `out_col` = 0; column register and counters cleared. Mid-frame reset abandons the frame; no `done`.
- `start` high in cycle 0 -> `busy` high cycle 1, first `rd_en` cycle 1 (addr KERNEL_BASE).
- Global column k (kernel k=0..4, image k=5+b*W+c) pushed at cycle 7+6k.
- Defaults: first image push cycle 37; first `conv_valid_out` (0,0) cycle 68; last image push cycle 5407; FLUSH push 5413; last `conv_valid_out` (27,27) cycle 5414; `done` and `busy` low at cycle 5415.
- Reads within a column use consecutive addresses stepping by W (image) or K (kernel).

## Test plan
- Reset idle: assert `rst` -> all outputs 0; `start` after release -> `busy`=1 next cycle, `rd_addr`=KERNEL_BASE.
- Kernel load: kernel(r,c)=10r+c -> 5 pushes with `conv_kernel_load`=1, push kc=2 carries {42,32,22,12,2} on data4..0, cycles 7,13,19,25,31.
- Full frame, pixel(r,c)=r*32+c -> 896 image pushes, 784 `conv_valid_out`, tags raster order (0,0)..(27,27), first at cycle 68, `done` at 5415.
- Band boundary: `conv_valid_out` with tag (0,27) occurs one cycle after push of band 1 column 0 (data {5,4,3,2,1}*32+0 rows 1..5).
- Reset mid-frame at cycle 2000 -> outputs 0 immediately; new `start` restarts from kernel fetch, identical cycle trace.
- `start` pulsed while busy and during `done` cycle -> ignored; exactly one `done` per accepted start.
